// File: rtl/multififo_wn_rm.sv
// Multi-port FIFO: up to WR pushes and RD pops per cycle, all-or-nothing per side,
// arbitrary DEPTH with conditional-subtract pointer wrap and sticky error flags.
module multififo_wn_rm #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int WR    = 1,
    parameter int RD    = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      softreset,
    input  logic [$clog2(WR+1)-1:0]   writes,
    input  logic [WIDTH*WR-1:0]       din,
    input  logic [$clog2(RD+1)-1:0]   reads,
    output logic [WIDTH*RD-1:0]       dout,
    output logic [RD-1:0]             dout_valid,
    output logic                      taken,
    output logic                      read_ok,
    output logic [15:0]               count,
    output logic [15:0]               frees,
    output logic                      overflow,
    output logic                      underflow
);

    localparam int AW   = $clog2(DEPTH);
    localparam int PW   = AW + 1;
    localparam int MEMN = 1 << AW;

    logic [WIDTH-1:0] mem_q [MEMN];
    logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
    logic [15:0]      count_q, count_d;
    logic             ovf_q, ovf_d, udf_q, udf_d;

    // Operands never exceed DEPTH-1 + DEPTH, so one subtraction wraps any depth.
    function automatic logic [PW-1:0] ptr_add(input logic [PW-1:0] p, input logic [PW-1:0] a);
        logic [PW-1:0] s;
        s = p + a;
        if (s >= PW'(DEPTH)) s = s - PW'(DEPTH);
        return s;
    endfunction

    function automatic logic [AW-1:0] idx_of(input logic [PW-1:0] p, input logic [PW-1:0] a);
        logic [PW-1:0] s;
        s = ptr_add(p, a);
        return s[AW-1:0];
    endfunction

    always_comb begin
        taken   = (32'(writes) <= WR) && (32'(writes) + 32'(count_q) <= DEPTH);
        read_ok = (32'(reads) <= RD) && (32'(reads) <= 32'(count_q));
        wptr_d  = taken   ? ptr_add(wptr_q, PW'(writes)) : wptr_q;
        rptr_d  = read_ok ? ptr_add(rptr_q, PW'(reads))  : rptr_q;
        count_d = count_q + (taken ? 16'(writes) : 16'd0) - (read_ok ? 16'(reads) : 16'd0);
        ovf_d   = ovf_q | ((writes != '0) && !taken);
        udf_d   = udf_q | ((reads != '0) && !read_ok);
    end

    always_comb begin
        dout       = '0;
        dout_valid = '0;
        for (int k = 0; k < RD; k++) begin
            if (32'(count_q) > k) begin
                dout_valid[k]          = 1'b1;
                dout[k*WIDTH +: WIDTH] = mem_q[idx_of(rptr_q, PW'(k))];
            end
        end
    end

    // Storage survives softreset; only the hard reset scrubs it.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < MEMN; i++) mem_q[i] <= '0;
        end else if (!softreset && taken) begin
            for (int k = 0; k < WR; k++) begin
                if (k < 32'(writes)) mem_q[idx_of(wptr_q, PW'(k))] <= din[k*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || softreset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign count     = count_q;
    assign frees     = 16'(DEPTH) - count_q;
    assign overflow  = ovf_q;
    assign underflow = udf_q;

endmodule

// File: tb/tb_multififo_wn_rm.sv
// Directed bench for multififo_wn_rm: an 8/1/2 instance for the scenario tests and
// a 6/3/2 instance for multi-write streaming across a non-power-of-2 wrap.
module tb_multififo_wn_rm;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // instance A: DEPTH=8, WR=1, RD=2
    logic        a_rst, a_srst;
    logic [0:0]  a_writes;
    logic [31:0] a_din;
    logic [1:0]  a_reads;
    logic [63:0] a_dout;
    logic [1:0]  a_dv;
    logic        a_taken, a_rok, a_ovf, a_udf;
    logic [15:0] a_count, a_frees;

    // instance B: DEPTH=6, WR=3, RD=2
    logic        b_rst, b_srst;
    logic [1:0]  b_writes;
    logic [95:0] b_din;
    logic [1:0]  b_reads;
    logic [63:0] b_dout;
    logic [1:0]  b_dv;
    logic        b_taken, b_rok, b_ovf, b_udf;
    logic [15:0] b_count, b_frees;

    multififo_wn_rm #(.WIDTH(32), .DEPTH(8), .WR(1), .RD(2)) u_a (
        .clk(clk), .rst(a_rst), .softreset(a_srst), .writes(a_writes), .din(a_din),
        .reads(a_reads), .dout(a_dout), .dout_valid(a_dv), .taken(a_taken),
        .read_ok(a_rok), .count(a_count), .frees(a_frees), .overflow(a_ovf),
        .underflow(a_udf)
    );

    multififo_wn_rm #(.WIDTH(32), .DEPTH(6), .WR(3), .RD(2)) u_b (
        .clk(clk), .rst(b_rst), .softreset(b_srst), .writes(b_writes), .din(b_din),
        .reads(b_reads), .dout(b_dout), .dout_valid(b_dv), .taken(b_taken),
        .read_ok(b_rok), .count(b_count), .frees(b_frees), .overflow(b_ovf),
        .underflow(b_udf)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input logic [31:0] v);
        a_writes = 1'b1; a_din = v;
        cyc();
        a_writes = 1'b0;
    endtask

    task automatic test_reset();
        a_rst = 1'b1; a_srst = 1'b0; a_writes = '0; a_din = '0; a_reads = '0;
        b_rst = 1'b1; b_srst = 1'b0; b_writes = '0; b_din = '0; b_reads = '0;
        cyc(); cyc();
        a_rst = 1'b0; b_rst = 1'b0;
        @(negedge clk);
        total++; if (a_count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", a_count); end
        total++; if (a_frees !== 16'd8) begin bad++; $display("FAIL reset_frees got=%0d exp=8", a_frees); end
        total++; if (a_dv !== 2'b00) begin bad++; $display("FAIL reset_valid got=%b exp=00", a_dv); end
        total++; if (a_dout !== 64'd0) begin bad++; $display("FAIL reset_dout got=%h exp=0", a_dout); end
        total++; if ({a_taken, a_rok} !== 2'b11) begin bad++; $display("FAIL reset_taken_rok got=%b exp=11", {a_taken, a_rok}); end
        total++; if ({a_ovf, a_udf} !== 2'b00) begin bad++; $display("FAIL reset_flags got=%b exp=00", {a_ovf, a_udf}); end
        total++; if (b_frees !== 16'd6) begin bad++; $display("FAIL reset_b_frees got=%0d exp=6", b_frees); end
        cyc();
    endtask

    task automatic test_basic();
        push_a(32'd5); push_a(32'd6); push_a(32'd7);
        total++; if (a_count !== 16'd3) begin bad++; $display("FAIL basic_count got=%0d exp=3", a_count); end
        total++; if (a_dv !== 2'b11) begin bad++; $display("FAIL basic_valid got=%b exp=11", a_dv); end
        total++; if (a_dout !== {32'd6, 32'd5}) begin bad++; $display("FAIL basic_dout got=%h exp=%h", a_dout, {32'd6, 32'd5}); end
        a_reads = 2'd2;
        @(negedge clk);
        total++; if (a_rok !== 1'b1) begin bad++; $display("FAIL basic_rok got=%b exp=1", a_rok); end
        cyc();
        a_reads = 2'd0;
        total++; if (a_dout !== {32'd0, 32'd7}) begin bad++; $display("FAIL basic_pop_dout got=%h exp=%h", a_dout, {32'd0, 32'd7}); end
        total++; if (a_dv !== 2'b01) begin bad++; $display("FAIL basic_pop_valid got=%b exp=01", a_dv); end
        total++; if (a_count !== 16'd1) begin bad++; $display("FAIL basic_pop_count got=%0d exp=1", a_count); end
        a_reads = 2'd1;
        cyc();
        a_reads = 2'd0;
        total++; if (a_count !== 16'd0) begin bad++; $display("FAIL basic_drain_count got=%0d exp=0", a_count); end
    endtask

    task automatic test_full_overflow();
        for (int i = 0; i < 8; i++) push_a(32'(10 + i));
        total++; if (a_count !== 16'd8) begin bad++; $display("FAIL full_count got=%0d exp=8", a_count); end
        total++; if (a_frees !== 16'd0) begin bad++; $display("FAIL full_frees got=%0d exp=0", a_frees); end
        a_writes = 1'b1; a_din = 32'd99; a_reads = 2'd2;
        @(negedge clk);
        total++; if ({a_taken, a_rok} !== 2'b01) begin bad++; $display("FAIL full_taken_rok got=%b exp=01", {a_taken, a_rok}); end
        cyc();
        a_writes = 1'b0; a_reads = 2'd0;
        total++; if (a_count !== 16'd6) begin bad++; $display("FAIL full_count_after got=%0d exp=6", a_count); end
        total++; if ({a_ovf, a_udf} !== 2'b10) begin bad++; $display("FAIL full_flags got=%b exp=10", {a_ovf, a_udf}); end
        total++; if (a_dout !== {32'd13, 32'd12}) begin bad++; $display("FAIL full_dout got=%h exp=%h", a_dout, {32'd13, 32'd12}); end
    endtask

    task automatic test_underflow();
        a_reads = 2'd2; cyc(); cyc();
        a_reads = 2'd1; cyc();
        a_reads = 2'd0;
        total++; if (a_count !== 16'd1) begin bad++; $display("FAIL udf_pre_count got=%0d exp=1", a_count); end
        a_writes = 1'b1; a_din = 32'd20; a_reads = 2'd2;
        @(negedge clk);
        total++; if ({a_taken, a_rok} !== 2'b10) begin bad++; $display("FAIL udf_taken_rok got=%b exp=10", {a_taken, a_rok}); end
        cyc();
        a_writes = 1'b0; a_reads = 2'd0;
        total++; if (a_count !== 16'd2) begin bad++; $display("FAIL udf_count got=%0d exp=2", a_count); end
        total++; if (a_udf !== 1'b1) begin bad++; $display("FAIL udf_flag got=%b exp=1", a_udf); end
        total++; if (a_dout !== {32'd20, 32'd17}) begin bad++; $display("FAIL udf_dout got=%h exp=%h", a_dout, {32'd20, 32'd17}); end
        a_reads = 2'd2;
        @(negedge clk);
        total++; if (a_rok !== 1'b1) begin bad++; $display("FAIL udf_retry_rok got=%b exp=1", a_rok); end
        cyc();
        a_reads = 2'd0;
        total++; if (a_count !== 16'd0) begin bad++; $display("FAIL udf_retry_count got=%0d exp=0", a_count); end
    endtask

    task automatic test_softreset();
        for (int i = 0; i < 4; i++) push_a(32'(30 + i));
        total++; if ({a_count, a_ovf} !== {16'd4, 1'b1}) begin bad++; $display("FAIL srst_pre got=%0d/%b exp=4/1", a_count, a_ovf); end
        a_srst = 1'b1; cyc(); a_srst = 1'b0;
        total++; if (a_count !== 16'd0) begin bad++; $display("FAIL srst_count got=%0d exp=0", a_count); end
        total++; if (a_frees !== 16'd8) begin bad++; $display("FAIL srst_frees got=%0d exp=8", a_frees); end
        total++; if (a_dv !== 2'b00) begin bad++; $display("FAIL srst_valid got=%b exp=00", a_dv); end
        total++; if ({a_ovf, a_udf} !== 2'b00) begin bad++; $display("FAIL srst_flags got=%b exp=00", {a_ovf, a_udf}); end
        push_a(32'hAB);
        total++; if (a_dout !== {32'd0, 32'hAB}) begin bad++; $display("FAIL srst_write got=%h exp=%h", a_dout, {32'd0, 32'hAB}); end
    endtask

    task automatic test_rst_midstream();
        a_writes = 1'b1; a_din = 32'hCD; a_reads = 2'd1; a_rst = 1'b1;
        cyc();
        a_writes = 1'b0; a_reads = 2'd0; a_rst = 1'b0;
        total++; if (a_count !== 16'd0) begin bad++; $display("FAIL rst_mid_count got=%0d exp=0", a_count); end
        total++; if ({a_dv, a_dout} !== 66'd0) begin bad++; $display("FAIL rst_mid_out got=%b/%h exp=0", a_dv, a_dout); end
        total++; if (a_frees !== 16'd8) begin bad++; $display("FAIL rst_mid_frees got=%0d exp=8", a_frees); end
        push_a(32'hEE);
        total++; if ({a_dv, a_dout} !== {2'b01, 32'd0, 32'hEE}) begin bad++; $display("FAIL rst_mid_write got=%b/%h exp=01/EE", a_dv, a_dout); end
    endtask

    task automatic test_out_of_range();
        a_rst = 1'b1; cyc(); a_rst = 1'b0;
        a_reads = 2'd1;
        @(negedge clk);
        total++; if (a_rok !== 1'b0) begin bad++; $display("FAIL empty_rok got=%b exp=0", a_rok); end
        cyc();
        a_reads = 2'd0;
        total++; if ({a_count, a_udf} !== {16'd0, 1'b1}) begin bad++; $display("FAIL empty_after got=%0d/%b exp=0/1", a_count, a_udf); end
        push_a(32'd1); push_a(32'd2); push_a(32'd3);
        a_reads = 2'd3;
        @(negedge clk);
        total++; if (a_rok !== 1'b0) begin bad++; $display("FAIL oor_rok got=%b exp=0", a_rok); end
        cyc();
        a_reads = 2'd0;
        total++; if (a_count !== 16'd3) begin bad++; $display("FAIL oor_count got=%0d exp=3", a_count); end
        total++; if (a_dout !== {32'd2, 32'd1}) begin bad++; $display("FAIL oor_dout got=%h exp=%h", a_dout, {32'd2, 32'd1}); end
        total++; if (a_ovf !== 1'b0) begin bad++; $display("FAIL oor_ovf got=%b exp=0", a_ovf); end
    endtask

    task automatic test_wrap_b();
        int nw, nr, cnt, r;
        logic w;
        nw = 1; nr = 1; cnt = 0;
        for (int i = 0; i < 26; i++) begin
            w = (i < 20) && (nw <= 58) && (cnt + 3 <= 6);
            r = (cnt >= 2) ? 2 : cnt;
            b_writes = w ? 2'd3 : 2'd0;
            b_din    = {32'(nw + 2), 32'(nw + 1), 32'(nw)};
            b_reads  = 2'(r);
            @(negedge clk);
            total++; if (b_count !== 16'(cnt)) begin bad++; $display("FAIL wrap_count i=%0d got=%0d exp=%0d", i, b_count, cnt); end
            total++; if (b_dout[31:0] !== ((cnt > 0) ? 32'(nr) : 32'd0)) begin bad++; $display("FAIL wrap_slot0 i=%0d got=%0d exp=%0d", i, b_dout[31:0], (cnt > 0) ? nr : 0); end
            total++; if (b_dout[63:32] !== ((cnt > 1) ? 32'(nr + 1) : 32'd0)) begin bad++; $display("FAIL wrap_slot1 i=%0d got=%0d exp=%0d", i, b_dout[63:32], (cnt > 1) ? nr + 1 : 0); end
            total++; if (b_dv !== {cnt > 1, cnt > 0}) begin bad++; $display("FAIL wrap_valid i=%0d got=%b exp=%b", i, b_dv, {cnt > 1, cnt > 0}); end
            total++; if ({b_taken, b_rok} !== 2'b11) begin bad++; $display("FAIL wrap_taken_rok i=%0d got=%b exp=11", i, {b_taken, b_rok}); end
            nr  = nr + r;
            cnt = cnt - r + (w ? 3 : 0);
            if (w) nw = nw + 3;
            cyc();
        end
        b_writes = '0; b_reads = '0;
        total++; if ({b_count, b_ovf, b_udf} !== 18'd0) begin bad++; $display("FAIL wrap_end got=%0d/%b/%b exp=0/0/0", b_count, b_ovf, b_udf); end
        total++; if (nr < 30) begin bad++; $display("FAIL wrap_progress got=%0d exp>=30", nr); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full_overflow();
        test_underflow();
        test_softreset();
        test_rst_midstream();
        test_out_of_range();
        test_wrap_b();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
